// File: rtl/image_row_streamer_pkg.sv
// ---------------------------------------------------------------------------
// image_row_streamer_pkg
// Definitions shared by the image loader and the row streamer: default frame
// geometry, the streamer FSM state encodings and a width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package image_row_streamer_pkg;

    localparam int DEF_NUM_BLOCKS = 3;
    localparam int DEF_BLOCK_SIZE = 2500;
    localparam int DEF_ROW_WIDTH  = 50;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    // Index width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/image_row_streamer_row_popcount.sv
// ---------------------------------------------------------------------------
// row_popcount
// Combinational count of set cells (obstacles) in one image row.
// Ports:
//   i_row    in  ROW_WIDTH  row cells, 1 = obstacle
//   o_count  out CNT_W      number of set bits in i_row
// ---------------------------------------------------------------------------
module row_popcount #(
    parameter int ROW_WIDTH = 50,
    parameter int CNT_W     = 6
) (
    input  logic [ROW_WIDTH-1:0] i_row,
    output logic [CNT_W-1:0]     o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < ROW_WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_row[i]);
        end
    end

endmodule

// File: rtl/image_row_streamer.sv
// ---------------------------------------------------------------------------
// image_row_streamer
// Accepts one BLOCK_SIZE-bit chunk at a time from the image loader and
// replays it as BLOCK_SIZE/ROW_WIDTH rows over a valid/ready handshake.
// NUM_BLOCKS chunks make one frame; frame_done pulses after the last row.
//
// Optional feature: define OBSTACLE_COUNT_EN to add the obstacle_count
// output, a running popcount of every row transferred in the current frame.
//
// Ports:
//   clk                   in   sole clock, rising edge
//   rst                   in   asynchronous active-high reset
//   chunk_din             in   chunk from loader, bit 0 = cell 0
//   chunk_valid           in   chunk_din valid
//   chunk_transfer_ready  out  chunk may be accepted; one rising edge/chunk
//   row_dout              out  current row, 1 = obstacle
//   row_valid             out  row_dout valid
//   row_ready             in   downstream accepts the row
//   row_idx               out  row index within the chunk
//   block_idx             out  chunk index within the frame
//   frame_done            out  one-cycle pulse after last row of last chunk
//   obstacle_count        out  (OBSTACLE_COUNT_EN only) frame obstacle total
//
// State table:
//   state     | meaning
//   ST_LOAD   | waiting for a chunk; ready low on first cycle, high after
//   ST_STREAM | presenting buffered rows, advancing on row_ready
// ---------------------------------------------------------------------------
module image_row_streamer
    import image_row_streamer_pkg::*;
#(
    parameter  int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter  int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter  int ROW_WIDTH  = DEF_ROW_WIDTH,
    localparam int ROWS       = BLOCK_SIZE / ROW_WIDTH,
    localparam int ROW_IDX_W  = clog2_min1(ROWS),
    localparam int BLK_IDX_W  = clog2_min1(NUM_BLOCKS),
    localparam int OBS_W      = clog2_min1(NUM_BLOCKS * BLOCK_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BLOCK_SIZE-1:0] chunk_din,
    input  logic                  chunk_valid,
    output logic                  chunk_transfer_ready,
    output logic [ROW_WIDTH-1:0]  row_dout,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [ROW_IDX_W-1:0]  row_idx,
    output logic [BLK_IDX_W-1:0]  block_idx,
    output logic                  frame_done
`ifdef OBSTACLE_COUNT_EN
    ,
    output logic [OBS_W-1:0]      obstacle_count
`endif
);

    state_e               r_state;
    logic                 r_ready;
    logic                 r_row_valid;
    logic                 r_frame_done;
    logic [ROW_IDX_W-1:0] r_row_idx;
    logic [BLK_IDX_W-1:0] r_block_idx;
    logic [ROW_WIDTH-1:0] r_row_dout;
    logic [ROW_WIDTH-1:0] r_rows [ROWS];

    logic                 w_capture;
    logic                 w_row_xfer;
    logic                 w_last_row;
    logic                 w_last_block;
    logic [ROW_IDX_W-1:0] w_next_idx;

    assign w_capture    = (r_state == ST_LOAD) && r_ready && chunk_valid;
    assign w_row_xfer   = (r_state == ST_STREAM) && row_ready;
    assign w_last_row   = (r_row_idx == ROW_IDX_W'(ROWS - 1));
    assign w_last_block = (r_block_idx == BLK_IDX_W'(NUM_BLOCKS - 1));
    assign w_next_idx   = r_row_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_ready      <= 1'b0;
            r_row_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_row_idx    <= '0;
            r_block_idx  <= '0;
            r_row_dout   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_rows[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    // Ready was cleared on entry, so raising it here gives the
                    // loader exactly one rising edge per LOAD visit.
                    r_ready <= 1'b1;
                    if (w_capture) begin
                        for (int i = 0; i < ROWS; i++) begin
                            r_rows[i] <= chunk_din[i*ROW_WIDTH +: ROW_WIDTH];
                        end
                        r_row_dout  <= chunk_din[ROW_WIDTH-1:0];
                        r_row_idx   <= '0;
                        r_ready     <= 1'b0;
                        r_row_valid <= 1'b1;
                        r_state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (row_ready) begin
                        if (w_last_row) begin
                            r_row_valid <= 1'b0;
                            r_state     <= ST_LOAD;
                            if (w_last_block) begin
                                r_block_idx  <= '0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_block_idx <= r_block_idx + 1'b1;
                            end
                        end else begin
                            r_row_idx  <= w_next_idx;
                            r_row_dout <= r_rows[w_next_idx];
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign chunk_transfer_ready = r_ready;
    assign row_dout             = r_row_dout;
    assign row_valid            = r_row_valid;
    assign row_idx              = r_row_idx;
    assign block_idx            = r_block_idx;
    assign frame_done           = r_frame_done;

`ifdef OBSTACLE_COUNT_EN
    localparam int POP_W = clog2_min1(ROW_WIDTH + 1);

    logic [POP_W-1:0] w_row_pop;
    logic [OBS_W-1:0] r_obs_count;

    row_popcount #(
        .ROW_WIDTH (ROW_WIDTH),
        .CNT_W     (POP_W)
    ) u_row_popcount (
        .i_row   (r_row_dout),
        .o_count (w_row_pop)
    );

    // The first transfer of block 0 restarts the total, so the previous
    // frame's value stays visible from frame_done until then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_obs_count <= '0;
        end else if (w_row_xfer) begin
            if ((r_block_idx == '0) && (r_row_idx == '0)) begin
                r_obs_count <= OBS_W'(w_row_pop);
            end else begin
                r_obs_count <= r_obs_count + OBS_W'(w_row_pop);
            end
        end
    end

    assign obstacle_count = r_obs_count;
`endif

endmodule
